uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
UART transmit framer. It is the transmit-side counterpart of the receive deserializer. It accepts a parallel byte with a valid strobe and emits one serial frame, LSB first: start bit, DATA_WIDTH data bits, optional parity bit, stop bit. It runs on the TX clock domain, and CLK is the bit clock (one serial bit per CLK cycle). It sits between the TX async FIFO read side and the TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..9).

Ports:
CLK  input  1  TX bit clock; all state changes on rising edge.
RST  input  1  asynchronous reset, active-high.
P_DATA  input  DATA_WIDTH  parallel word to transmit.
DATA_VALID  input  1  request; P_DATA and config are valid this cycle.
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line; idles high.
BUSY  output  1  frame in progress; the word is accepted and not yet fully sent.

Behaviour:
- Single clock CLK. Reset is asynchronous and active-high on RST. All outputs are registered.
- Reset values: state=IDLE, TX_OUT=1, BUSY=0, shift register=0, bit counter=0, latched PAR_EN/PAR_TYP=0.
- RST asserted mid-frame aborts immediately: TX_OUT=1 and BUSY=0 asynchronously. The partial frame is lost and is not resumed after release.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - If DATA_VALID=1 at a rising edge, latch P_DATA, PAR_EN and PAR_TYP, and compute parity from the latched data.
  - Go to START.
  - DATA_VALID=0 means stay in IDLE.
- START: TX_OUT=0, BUSY=1, lasts exactly 1 cycle, then DATA with bit counter=0.
- DATA:
  - TX_OUT = data bit [counter], LSB first.
  - The counter increments each cycle. DATA lasts exactly DATA_WIDTH cycles.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: lasts 1 cycle.
  - TX_OUT = XOR-reduce(data) when PAR_TYP=0 (even).
  - TX_OUT = inverted XOR-reduce(data) when PAR_TYP=1 (odd).
- STOP: TX_OUT=1, BUSY=1, lasts 1 cycle, then IDLE.
- Latency:
  - DATA_VALID sampled at edge N: TX_OUT=0 (start) is visible after edge N, and BUSY rises after the same edge N.
  - Frame occupies 2+DATA_WIDTH(+1 if parity) cycles: 10 or 11 for width 8.
  - BUSY falls after the edge that ends STOP.
- Handshake:
  - DATA_VALID is sampled only in IDLE. It is ignored while BUSY=1, and the producer must hold its request until it sees BUSY=0.
  - Minimum spacing between frames is one IDLE cycle, so back-to-back period is frame length + 1.
- Changes on P_DATA, PAR_EN or PAR_TYP after acceptance have no effect on the frame in flight.
- DATA_VALID held high continuously sends the word present at each IDLE sample. This repeats frames with a 1-cycle idle gap.
- TX_OUT must never glitch. It is driven from a flop, not from combinational decode of state.

Test Plan:
- Reset: RST=1 mid-DATA state -> TX_OUT=1 and BUSY=0 immediately. After release, with DATA_VALID=0, the line stays 1 for 20 cycles.
- No parity: P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1. BUSY is high for exactly 10 cycles, rising the same edge as the start bit.
- Even parity: P_DATA=0x80, PAR_EN=1, PAR_TYP=0 -> 0,0,0,0,0,0,0,0,1,1(parity),1(stop). BUSY is high for 11 cycles.
- Odd parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit=1. Same frame with PAR_TYP=0 -> parity bit=0.
- Ignore while busy: accept 0x3C, then pulse DATA_VALID with P_DATA=0xFF during DATA and change P_DATA each cycle -> the frame carries 0x3C only, and no second frame is sent.
- Back-to-back: DATA_VALID held high with P_DATA=0x55, PAR_EN=0 -> frames repeat with period 11 cycles. Exactly one TX_OUT=1 idle cycle separates each stop bit from the next start bit, and BUSY is low only on that cycle.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: serialises one parallel word per request into
// start bit, DATA_WIDTH data bits (LSB first), optional parity bit and stop bit.
// CLK is the bit clock, so each frame bit occupies exactly one CLK cycle.
module uart_tx_frame #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   localparam int unsigned      CntW    = $clog2(DATA_WIDTH);
   localparam logic [CntW-1:0]  LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CntW-1:0]       cnt_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   // XOR-reduce of the accepted word; taken at acceptance so the parity
   // cycle needs no wide reduction in the serial path.
   logic                  par_xor_q;

   // Frame sequencer; TX_OUT and BUSY are registered so the line never glitches.
   // Each state loads TX_OUT with the bit the *next* state must present.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         TX_OUT    <= 1'b1;
         BUSY      <= 1'b0;
         shift_q   <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         par_xor_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               TX_OUT <= 1'b1;
               BUSY   <= 1'b0;
               if (DATA_VALID) begin
                  shift_q   <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  par_xor_q <= ^P_DATA;
                  TX_OUT    <= 1'b0;
                  BUSY      <= 1'b1;
                  state_q   <= StStart;
               end
            end

            StStart: begin
               TX_OUT  <= shift_q[0];
               shift_q <= shift_q >> 1;
               cnt_q   <= '0;
               state_q <= StData;
            end

            StData: begin
               if (cnt_q == LastBit) begin
                  cnt_q <= '0;
                  if (par_en_q) begin
                     // Odd parity is the inverse of the even-parity bit.
                     TX_OUT  <= par_xor_q ^ par_typ_q;
                     state_q <= StParity;
                  end else begin
                     TX_OUT  <= 1'b1;
                     state_q <= StStop;
                  end
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  TX_OUT  <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end

            StParity: begin
               TX_OUT  <= 1'b1;
               state_q <= StStop;
            end

            StStop: begin
               // Always return through one IDLE cycle before the next frame.
               TX_OUT  <= 1'b1;
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               TX_OUT  <= 1'b1;
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
